// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, control-word bit
// positions, one-hot T-states and the control words for each micro-step.
package sap1_pkg;

    // Opcodes taken from IR[7:4]
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control-word bit positions
    localparam int unsigned CON_CP = 11;
    localparam int unsigned CON_EP = 10;
    localparam int unsigned CON_LM = 9;
    localparam int unsigned CON_CE = 8;
    localparam int unsigned CON_LI = 7;
    localparam int unsigned CON_EI = 6;
    localparam int unsigned CON_LA = 5;
    localparam int unsigned CON_EA = 4;
    localparam int unsigned CON_SU = 3;
    localparam int unsigned CON_EU = 2;
    localparam int unsigned CON_LB = 1;
    localparam int unsigned CON_LO = 0;

    // One-hot ring positions, bit0 = T1
    localparam logic [5:0] TS_T1 = 6'b000001;
    localparam logic [5:0] TS_T2 = 6'b000010;
    localparam logic [5:0] TS_T3 = 6'b000100;
    localparam logic [5:0] TS_T4 = 6'b001000;
    localparam logic [5:0] TS_T5 = 6'b010000;
    localparam logic [5:0] TS_T6 = 6'b100000;
    localparam logic [5:0] TS_HALT = 6'b000000;

    typedef enum logic [5:0] {
        ST_T1   = TS_T1,
        ST_T2   = TS_T2,
        ST_T3   = TS_T3,
        ST_T4   = TS_T4,
        ST_T5   = TS_T5,
        ST_T6   = TS_T6,
        ST_HALT = TS_HALT
    } tstate_t;

    // Control words per micro-step
    localparam logic [11:0] CON_IDLE     = '0;
    localparam logic [11:0] CON_FETCH_T1 = (12'd1 << CON_EP) | (12'd1 << CON_LM);
    localparam logic [11:0] CON_FETCH_T2 = (12'd1 << CON_CP);
    localparam logic [11:0] CON_FETCH_T3 = (12'd1 << CON_CE) | (12'd1 << CON_LI);
    localparam logic [11:0] CON_ADDR_T4  = (12'd1 << CON_EI) | (12'd1 << CON_LM);
    localparam logic [11:0] CON_LDA_T5   = (12'd1 << CON_CE) | (12'd1 << CON_LA);
    localparam logic [11:0] CON_ARITH_T5 = (12'd1 << CON_CE) | (12'd1 << CON_LB);
    localparam logic [11:0] CON_ADD_T6   = (12'd1 << CON_LA) | (12'd1 << CON_EU);
    localparam logic [11:0] CON_SUB_T6   = (12'd1 << CON_LA) | (12'd1 << CON_SU) | (12'd1 << CON_EU);
    localparam logic [11:0] CON_OUT_T4   = (12'd1 << CON_EA) | (12'd1 << CON_LO);

endpackage

// File: rtl/sap1_step_sync.sv
// Single-step input conditioning: 2-FF synchroniser followed by a rising-edge
// detector. step_pulse is high for one clock, two edges after step_async rises,
// so the ring moves on the third edge.
module sap1_step_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic step_async,
    output logic step_pulse
);

    logic meta;
    logic sync;
    logic sync_prev;

    // Synchronise the asynchronous step request and keep one sample of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            meta      <= step_async;
            sync      <= meta;
            sync_prev <= sync;
        end
    end

    assign step_pulse = sync & ~sync_prev;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state one-hot ring plus halt flag, with the
// control word decoded from the ring position and the IR opcode.
// Optional single-step mode: define SAP1_CTRL_SINGLE_STEP_EN to add i_step.
module sap1_controller
    import sap1_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [3:0]  i_opcode,
`ifdef SAP1_CTRL_SINGLE_STEP_EN
    input  logic        i_step,
`endif
    output logic [11:0] o_con,
    output logic [5:0]  o_tstate,
    output logic        o_halt
);

    tstate_t     state;
    logic        halt;
    logic        advance;
    logic [11:0] con;

`ifdef SAP1_CTRL_SINGLE_STEP_EN
    sap1_step_sync u_step_sync (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .step_async (i_step),
        .step_pulse (advance)
    );
`else
    assign advance = 1'b1;
`endif

    // Ring sequencer; HLT leaves the ring empty and freezes until reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_T1;
            halt  <= 1'b0;
        end else if (advance && !halt) begin
            case (state)
                ST_T1: state <= ST_T2;
                ST_T2: state <= ST_T3;
                ST_T3: state <= ST_T4;
                ST_T4: begin
                    if (i_opcode == OP_HLT) begin
                        state <= ST_HALT;
                        halt  <= 1'b1;
                    end else begin
                        state <= ST_T5;
                    end
                end
                ST_T5: state <= ST_T6;
                ST_T6: state <= ST_T1;
                default: state <= state;
            endcase
        end
    end

    // Control-word decode from ring position and opcode
    always_comb begin
        con = CON_IDLE;
        case (state)
            ST_T1: con = CON_FETCH_T1;
            ST_T2: con = CON_FETCH_T2;
            ST_T3: con = CON_FETCH_T3;
            ST_T4: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB: con = CON_ADDR_T4;
                    OP_OUT:                 con = CON_OUT_T4;
                    default:                con = CON_IDLE;
                endcase
            end
            ST_T5: begin
                case (i_opcode)
                    OP_LDA:         con = CON_LDA_T5;
                    OP_ADD, OP_SUB: con = CON_ARITH_T5;
                    default:        con = CON_IDLE;
                endcase
            end
            ST_T6: begin
                case (i_opcode)
                    OP_ADD:  con = CON_ADD_T6;
                    OP_SUB:  con = CON_SUB_T6;
                    default: con = CON_IDLE;
                endcase
            end
            default: con = CON_IDLE;
        endcase
    end

    assign o_con    = con;
    assign o_tstate = state;
    assign o_halt   = halt;

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller. A step-counter model predicts the
// outputs every cycle; directed instruction sequences carry literal words.
module tb_sap1_controller;

    logic        i_clk;
    logic        i_reset_n;
    logic [3:0]  i_opcode;
`ifdef SAP1_CTRL_SINGLE_STEP_EN
    logic        i_step;
`endif
    logic [11:0] o_con;
    logic [5:0]  o_tstate;
    logic        o_halt;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    int m_step = 0;
    bit m_halt = 0;

    sap1_controller dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_opcode  (i_opcode),
`ifdef SAP1_CTRL_SINGLE_STEP_EN
        .i_step    (i_step),
`endif
        .o_con     (o_con),
        .o_tstate  (o_tstate),
        .o_halt    (o_halt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control word for micro-step s (0 = T1) of an instruction
    function automatic logic [11:0] model_con(input int s, input logic [3:0] op);
        logic [11:0] lda [6];
        logic [11:0] add [6];
        logic [11:0] sub [6];
        logic [11:0] out [6];
        lda = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
        add = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024};
        sub = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C};
        out = '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000};
        if (s < 3) return lda[s];
        case (op)
            4'h0:    return lda[s];
            4'h1:    return add[s];
            4'h2:    return sub[s];
            4'hE:    return out[s];
            default: return 12'h000;
        endcase
    endfunction

    // Model: instruction step counter, halts when HLT finishes its 4th step
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_step = 0;
            m_halt = 0;
        end else if (!m_halt) begin
            if (m_step == 3 && i_opcode == 4'hF) m_halt = 1;
            else m_step = (m_step + 1) % 6;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge i_clk) begin
        if (check_en && i_reset_n) begin
            check("model_con", 32'(o_con), m_halt ? 32'h0 : 32'(model_con(m_step, i_opcode)));
            check("model_tstate", 32'(o_tstate), m_halt ? 32'h0 : (32'd1 << m_step));
            check("model_halt", 32'(o_halt), 32'(m_halt));
        end
    end

    // Run one instruction from T1 back to T1, checking literal words per step
    task automatic run_instr(input string name, input logic [3:0] op, input logic [11:0] e [6]);
        i_opcode = op;
        #1;
        check({name, "_t1"}, 32'(o_con), 32'(e[0]));
        for (int k = 1; k < 6; k++) begin
            @(posedge i_clk);
            #2;
            check($sformatf("%s_t%0d", name, k + 1), 32'(o_con), 32'(e[k]));
        end
        @(posedge i_clk);
        #2;
        check({name, "_ring_back"}, 32'(o_tstate), 32'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        i_opcode  = 4'h0;
`ifdef SAP1_CTRL_SINGLE_STEP_EN
        i_step = 1'b0;
`endif
        repeat (3) @(posedge i_clk);
        #2;
        check("rst_tstate", 32'(o_tstate), 32'h01);
        check("rst_con", 32'(o_con), 32'h600);
        check("rst_halt", 32'(o_halt), 32'h0);
        i_reset_n = 1'b1;

`ifdef SAP1_CTRL_SINGLE_STEP_EN
        begin
            int n;
            repeat (50) begin
                @(posedge i_clk);
                #2;
                check("idle_tstate", 32'(o_tstate), 32'h01);
                check("idle_con", 32'(o_con), 32'h600);
            end
            i_step = 1'b1;
            n = 0;
            while (o_tstate == 6'b000001 && n < 10) begin
                @(posedge i_clk);
                #1;
                n++;
            end
            check("step_latency", 32'(n), 32'd3);
            check("step_t2", 32'(o_tstate), 32'h02);
            check("step_con", 32'(o_con), 32'h800);
            repeat (7) @(posedge i_clk);
            #2;
            i_step = 1'b0;
            repeat (10) begin
                @(posedge i_clk);
                #2;
                check("step_once", 32'(o_tstate), 32'h02);
            end
        end
`else
        check_en = 1;
        run_instr("lda", 4'h0, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000});
        run_instr("add", 4'h1, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024});
        run_instr("sub", 4'h2, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C});
        run_instr("out", 4'hE, '{12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000});
        run_instr("nop", 4'h5, '{12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000});

        // HLT: fetch, T4 idle, then frozen
        i_opcode = 4'hF;
        #1;
        check("hlt_t1", 32'(o_con), 32'h600);
        @(posedge i_clk); #2;
        check("hlt_t2", 32'(o_con), 32'h800);
        @(posedge i_clk); #2;
        check("hlt_t3", 32'(o_con), 32'h180);
        @(posedge i_clk); #2;
        check("hlt_t4", 32'(o_con), 32'h000);
        check("hlt_t4_halt", 32'(o_halt), 32'h0);
        @(posedge i_clk); #2;
        check("hlt_halt", 32'(o_halt), 32'h1);
        check("hlt_tstate", 32'(o_tstate), 32'h00);
        check("hlt_con", 32'(o_con), 32'h000);
        repeat (20) @(posedge i_clk);
        #2;
        check("hlt_frozen_tstate", 32'(o_tstate), 32'h00);
        check("hlt_frozen_halt", 32'(o_halt), 32'h1);

        // Reset pulse leaves halt
        i_reset_n = 1'b0;
        #1;
        check("unhalt_tstate", 32'(o_tstate), 32'h01);
        check("unhalt_con", 32'(o_con), 32'h600);
        check("unhalt_halt", 32'(o_halt), 32'h0);
        @(posedge i_clk); #2;
        i_reset_n = 1'b1;
        i_opcode  = 4'h0;

        // Asynchronous reset in the middle of T5
        repeat (4) @(posedge i_clk);
        #2;
        check("mid_t5_con", 32'(o_con), 32'h120);
        check("mid_t5_tstate", 32'(o_tstate), 32'h10);
        i_reset_n = 1'b0;
        #1;
        check("async_rst_tstate", 32'(o_tstate), 32'h01);
        check("async_rst_con", 32'(o_con), 32'h600);
        @(posedge i_clk); #2;
        i_reset_n = 1'b1;
        run_instr("nop2", 4'h5, '{12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000});
        run_instr("add2", 4'h1, '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h024});
        check_en = 0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
